// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: latches PC, runs a req/ack word read and loads the instruction register.
// Optional FETCH_TIMEOUT_EN adds a REQ wait limit with a sticky fetch_error flag.
module instruction_fetch_unit #(
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              pc_increment,
    output logic              busy
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic              fetch_error
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
`ifdef FETCH_TIMEOUT_EN
        err_d      = err_q;
        cnt_d      = (state_q == REQ) ? cnt_q + CNT_W'(1) : '0;
`endif
        unique case (state_q)
            IDLE: if (fetch_start && !flush) begin
                state_d    = REQ;
                mem_addr_d = pc_addr;
                valid_d    = 1'b0;
            end
            REQ: begin
                // flush beats ack; both beat the timeout
                if (flush) state_d = IDLE;
                else if (mem_rd_ack) begin
                    instr_d = mem_rd_data;
                    state_d = DONE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_rd_req   = state_q == REQ;
    assign instr_out    = instr_q;
    assign instr_valid  = valid_q;
    assign pc_increment = state_q == DONE;
    assign busy         = state_q != IDLE;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_error  = err_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and random checks of the fetch unit against a fetch-level model.
module tb_instruction_fetch_unit;
    localparam int AW = 14, DW = 16, TO = 8;

    logic          clk = 1'b0, rst_n = 1'b0, fetch_start = 1'b0, flush = 1'b0, mem_rd_ack = 1'b0;
    logic [AW-1:0] pc_addr = '0, mem_addr;
    logic [DW-1:0] mem_rd_data = '0, instr_out;
    logic          mem_rd_req, instr_valid, pc_increment, busy;
    logic          fetch_error;

    instruction_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .flush(flush), .pc_addr(pc_addr),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .instr_out(instr_out), .instr_valid(instr_valid),
        .pc_increment(pc_increment), .busy(busy)
`ifdef FETCH_TIMEOUT_EN
        , .fetch_error(fetch_error)
`endif
    );
`ifndef FETCH_TIMEOUT_EN
    assign fetch_error = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, n_inc = 0, n_req = 0;
    logic prev_inc = 1'b0;

    // fetch-level model: an outstanding read, a completed word awaiting hand-off, the register contents
    bit            m_outstanding, m_completed, m_valid, m_err;
    int            m_waited;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_outstanding = 0; m_completed = 0; m_valid = 0; m_err = 0; m_waited = 0;
            m_addr = '0; m_instr = '0;
        end else if (m_completed) begin
            m_completed = 0;
            m_valid = 1;
        end else if (m_outstanding) begin
            m_waited++;
            if (flush) m_outstanding = 0;
            else if (mem_rd_ack) begin
                m_instr = mem_rd_data;
                m_outstanding = 0;
                m_completed = 1;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (m_waited == TO) begin
                m_err = 1;
                m_outstanding = 0;
            end
`endif
        end else if (fetch_start && !flush) begin
            m_addr = pc_addr;
            m_outstanding = 1;
            m_valid = 0;
            m_waited = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (pc_increment) n_inc++;
        if (mem_rd_req) n_req++;
        if (pc_increment && prev_inc) check("inc_twice", 1, 0);
        prev_inc = pc_increment;
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_rd_req", 32'(mem_rd_req), 32'(m_outstanding));
        check("instr_out", 32'(instr_out), 32'(m_instr));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("pc_increment", 32'(pc_increment), 32'(m_completed));
        check("busy", 32'(busy), 32'(m_outstanding || m_completed));
        check("fetch_error", 32'(fetch_error), 32'(m_err));
    endtask

    initial begin
        logic [DW-1:0] prev;
        int inc0;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        check("rst_instr", 32'(instr_out), 0);

        // 1: immediate ack, 3 edges to valid
        pc_addr = 14'h2000; fetch_start = 1; n_inc = 0;
        step();
        fetch_start = 0; mem_rd_ack = 1; mem_rd_data = 16'hA5C3;
        step();
        check("t1_valid_early", 32'(instr_valid), 0);
        mem_rd_ack = 0;
        step();
        check("t1_valid", 32'(instr_valid), 1);
        check("t1_instr", 32'(instr_out), 32'hA5C3);
        check("t1_addr", 32'(mem_addr), 32'h2000);
        check("t1_incs", n_inc, 1);

        // 2: ack after 5 waiting cycles, pc moves mid-wait
        fetch_start = 1; n_inc = 0; n_req = 0;
        step();
        fetch_start = 0; pc_addr = 14'h1234; mem_rd_data = 16'h5A5A;
        repeat (5) step();
        mem_rd_ack = 1;
        step();
        mem_rd_ack = 0;
        step();
        check("t2_addr", 32'(mem_addr), 32'h2000);
        check("t2_req_cycles", n_req, 6);
        check("t2_incs", n_inc, 1);
        check("t2_instr", 32'(instr_out), 32'h5A5A);

        // 3: flush together with ack in 2nd REQ cycle
        prev = instr_out; n_inc = 0;
        fetch_start = 1;
        step();
        fetch_start = 0;
        step();
        flush = 1; mem_rd_ack = 1; mem_rd_data = 16'hFFFF;
        step();
        flush = 0; mem_rd_ack = 0;
        check("t3_instr", 32'(instr_out), 32'(prev));
        check("t3_valid", 32'(instr_valid), 0);
        check("t3_busy", 32'(busy), 0);
        step();
        check("t3_incs", n_inc, 0);

        // 4: start held across two fetches
        n_inc = 0; pc_addr = 14'h2000; fetch_start = 1; mem_rd_ack = 1; mem_rd_data = 16'h0101;
        step();
        check("t4_addr0", 32'(mem_addr), 32'h2000);
        pc_addr = 14'h2001;
        repeat (4) step();
        check("t4_addr1", 32'(mem_addr), 32'h2001);
        fetch_start = 0; mem_rd_ack = 0;
        step();
        check("t4_incs", n_inc, 2);

        // 5: reset mid-REQ, then a stray ack
        fetch_start = 1; pc_addr = 14'h0ABC;
        step();
        fetch_start = 0; rst_n = 0;
        step();
        rst_n = 1;
        check("t5_busy", 32'(busy), 0);
        check("t5_addr", 32'(mem_addr), 0);
        mem_rd_ack = 1; mem_rd_data = 16'h1111;
        step();
        mem_rd_ack = 0;
        check("t5_instr", 32'(instr_out), 0);
        check("t5_valid", 32'(instr_valid), 0);

`ifdef FETCH_TIMEOUT_EN
        // 6: no ack until timeout
        n_inc = 0; n_req = 0; fetch_start = 1;
        step();
        fetch_start = 0;
        for (int i = 0; i < 30 && busy; i++) step();
        check("t6_error", 32'(fetch_error), 1);
        check("t6_req", 32'(mem_rd_req), 0);
        check("t6_req_cycles", n_req, TO);
        check("t6_incs", n_inc, 0);
        rst_n = 0;
        step();
        rst_n = 1;
        check("t6_err_clr", 32'(fetch_error), 0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            fetch_start = ($urandom_range(0, 2) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            mem_rd_ack  = ($urandom_range(0, 5) == 0);
            mem_rd_data = DW'($urandom);
            pc_addr     = AW'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter in the multicycle computer.
- Captures the current PC address, issues a word read to instruction memory over a req/ack handshake, and latches the returned word into the instruction register.
- Pulses pc_increment back to the program counter once per completed fetch.
- Sequenced by the control unit via fetch_start; supports abort (flush) for jumps and branches.

Parameters:
- ADDR_W, 14, instruction address width; matches the program counter output.
- DATA_W, 16, instruction word width.
- TIMEOUT_CYCLES, 64, max cycles waiting for mem_rd_ack. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- fetch_start  input  1  control unit request to begin a fetch. Sampled only in IDLE.
- flush  input  1  abort an in-flight fetch; from the control unit on jump or branch.
- pc_addr  input  ADDR_W  current address from the program counter.
- mem_addr  output  ADDR_W  registered read address to instruction memory.
- mem_rd_req  output  1  read request, held until ack or abort.
- mem_rd_ack  input  1  memory completion strobe; valid only while mem_rd_req=1.
- mem_rd_data  input  DATA_W  read data, valid in the cycle mem_rd_ack=1.
- instr_out  output  DATA_W  instruction register.
- instr_valid  output  1  instr_out holds a fetched word not yet superseded.
- pc_increment  output  1  one-cycle pulse to the program counter.
- busy  output  1  high in any state other than IDLE.
- fetch_error  output  1  sticky timeout flag. Present only with FETCH_TIMEOUT_EN.

Behaviour:
- Reset: when rst_n=0 at a rising edge, the block goes to IDLE and clears all outputs to 0: mem_addr, mem_rd_req, instr_out, instr_valid, pc_increment, busy, fetch_error. Reset wins over every other input, including mid-fetch. Any later ack for an aborted fetch is ignored.
- States: IDLE, REQ, DONE. Encoding is free.
- IDLE:
  - If fetch_start=1 and flush=0: mem_addr<=pc_addr, mem_rd_req<=1, instr_valid<=0, go to REQ.
  - If fetch_start=1 and flush=1 in the same cycle: the start is ignored.
- REQ:
  - mem_rd_req stays 1 and mem_addr is stable until the request leaves REQ.
  - On mem_rd_ack=1 (flush=0): instr_out<=mem_rd_data, mem_rd_req<=0, go to DONE.
  - An ack can arrive as early as the first cycle that mem_rd_req=1. Minimum fetch latency is therefore 3 edges from the fetch_start sample to instr_valid=1.
- DONE (exactly one cycle): pc_increment=1, instr_valid<=1, then go to IDLE.
  - pc_increment is high only in DONE, never two consecutive cycles.
  - instr_valid=1 from the cycle after DONE until the next accepted fetch_start.
- flush:
  - In REQ: mem_rd_req<=0, go to IDLE, no pc_increment, instr_out unchanged, instr_valid stays 0.
  - flush and ack in the same cycle: flush wins and the data is discarded.
  - In DONE: ignored; the increment still occurs.
  - In IDLE: no effect.
- fetch_start while busy=1 is ignored and not queued.
- pc_addr is sampled only on fetch start. Later pc_addr changes do not affect mem_addr.
- mem_rd_ack outside REQ is ignored.
- busy=1 in REQ and DONE.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: fetch_error<=1, mem_rd_req<=0, go to IDLE, no pc_increment.
  - fetch_error clears only on reset. Flush or ack on the timeout cycle takes priority over the timeout.
- Undefined: no counter and no fetch_error port; REQ waits indefinitely.

Test Plan:
- Reset, then pc_addr=0x2000, fetch_start pulse, ack with data 0xA5C3 on the 1st REQ cycle -> mem_addr=0x2000, instr_out=0xA5C3, one pc_increment pulse, instr_valid=1 three edges after start.
- Ack delayed 5 cycles, pc_addr changed to 0x1234 mid-wait -> mem_addr stays 0x2000, mem_rd_req high for 6 cycles, single pc_increment.
- flush asserted in the 2nd REQ cycle together with ack (data 0xFFFF) -> instr_out keeps its previous value, no pc_increment, instr_valid=0, busy=0 next cycle.
- fetch_start held high across two back-to-back fetches at 0x2000 then 0x2001 -> exactly two pc_increment pulses, no overlap; start ignored while busy.
- rst_n=0 while in REQ -> next cycle all outputs 0 and state IDLE; a later stray ack produces no change.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8, no ack -> fetch_error=1 after 8 REQ cycles, mem_rd_req=0, no pc_increment.
